rocc_cmd_arbiter: RTL and testbench
===================================

// Module: rocc_cmd_arbiter
// PURPOSE
//  Shares one RoCC accelerator (e.g. the accumulator black box) among NREQ command sources.
//  Round-robin arbitration on the command channel; in-order tracking of the source of every xd=1 command.
//  Routes each accelerator response back to the source that issued the command.
//  Sits between per-source RoCC cmd/resp ports and a single accelerator's cmd/resp ports.
// PARAMETERS
//  NREQ            2     number of command sources (>=2)
//  XLEN            64    operand/result width
//  MAX_OUTST       4     max outstanding xd=1 commands (power of 2); depth of the ID FIFO
//  TIMEOUT_CYCLES  1024  watchdog limit in cycles (used only with ROCC_ARB_WDOG_EN)
// PORTS
//  clock          in   1            clock, rising edge
//  reset          in   1            synchronous, active-high
//  src_cmd_valid  in   NREQ         per-source command valid
//  src_cmd_ready  out  NREQ         per-source command ready
//  src_cmd_funct  in   NREQ*7       packed funct fields, source i at [7i+:7]
//  src_cmd_rd     in   NREQ*5       packed rd fields
//  src_cmd_xd     in   NREQ         command expects a response
//  src_cmd_rs1    in   NREQ*XLEN    packed rs1 operands
//  src_cmd_rs2    in   NREQ*XLEN    packed rs2 operands
//  acc_cmd_valid  out  1            command to the accelerator
//  acc_cmd_ready  in   1            accelerator accepts the command
//  acc_cmd_funct  out  7            granted funct
//  acc_cmd_rd     out  5            granted rd
//  acc_cmd_xd     out  1            granted xd
//  acc_cmd_rs1    out  XLEN         granted rs1
//  acc_cmd_rs2    out  XLEN         granted rs2
//  acc_resp_valid in   1            response from the accelerator
//  acc_resp_ready out  1            response accepted
//  acc_resp_rd    in   5            response rd
//  acc_resp_data  in   XLEN         response data
//  src_resp_valid out  NREQ         one-hot response valid
//  src_resp_ready in   NREQ         per-source response ready
//  src_resp_rd    out  5            shared; copy of acc_resp_rd
//  src_resp_data  out  XLEN         shared; copy of acc_resp_data
//  busy           out  1            acc_cmd_valid OR ID FIFO non-empty
//  err_spurious   out  1            sticky; set by a response arriving while the ID FIFO is empty
//  wdog_irq       out  1            sticky watchdog flag
//  err_clear      in   1            clears err_spurious and wdog_irq
// BEHAVIOUR
//  Reset values
//   - All outputs 0; ID FIFO empty; round-robin pointer = source 0; grant unlocked.
//  Arbitration
//   - Candidates: valid sources, excluding xd=1 sources while the ID FIFO is full.
//   - Search starts at the source after the last-accepted source.
//   - Once acc_cmd_valid is high, the grant locks until acc_cmd_ready. Payload is held stable (AXI-style).
//   - src_cmd_ready[i] = grant[i] & acc_cmd_ready. At most one source is ready per cycle.
//   - Latency: 0 cycles. acc_cmd_* is combinational from the locked or new grant; no buffering.
//  ID FIFO
//   - A source ID is pushed on each accepted command with xd=1.
//   - A pop happens on each accepted response while the FIFO is non-empty.
//   - When full, a push is blocked even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle when not full: count is unchanged.
//  Response routing
//   - head = FIFO head ID.
//   - src_resp_valid[head] = acc_resp_valid & !empty.
//   - acc_resp_ready = src_resp_ready[head] when non-empty.
//  Spurious response
//   - When empty: acc_resp_ready = 1, the response is dropped, err_spurious is set.
//   - When err_clear and a set event occur in the same cycle, the set wins.
//  Reset mid-operation
//   - In-flight IDs are discarded. Responses that arrive after reset are treated as spurious.
// CONFIGURATION
//  Macro ROCC_ARB_WDOG_EN
//   - Defined: a counter increments each cycle while the FIFO is non-empty and no pop occurs.
//     It clears on a pop or when the FIFO is empty.
//     When the count reaches TIMEOUT_CYCLES-1, wdog_irq is set and the counter saturates.
//   - Undefined: no counter; wdog_irq is tied to 0.
// STRUCTURE
//  Package rocc_arb_pkg
//   - Constants FUNCT_W=7, RD_W=5.
//   - Function id_w(n) = $clog2(n).
//   - Typedef cmd_t {funct, rd, xd, rs1, rs2}.
//  Sub-module rocc_id_fifo
//   - Parameterised depth/width; synchronous reset.
//   - Ports push/pop/full/empty/head/count.
// TESTING
//  1. Only source 1 valid, xd=0, acc_cmd_ready=1 -> acc_cmd_rs1 == src1 rs1 the same cycle; FIFO stays empty; busy drops the next cycle.
//  2. Both sources valid continuously, ready=1 -> grants alternate 0,1,0,1. With ready low for 3 cycles: payload stable and grant unchanged.
//  3. Issue 4 xd=1 commands (src 0,1,1,0) -> 5th xd=1 stalls while a concurrent xd=0 passes.
//     Responses route in order 0,1,1,0.
//  4. Hold src_resp_ready[head]=0 for 2 cycles -> acc_resp_ready=0 and no pop; pops when ready rises.
//  5. acc_resp_valid with FIFO empty -> acc_resp_ready=1 and err_spurious=1.
//     err_clear -> err_spurious returns to 0 the next cycle.
//  6. WDOG_EN, TIMEOUT_CYCLES=8: one xd=1 command, no response -> wdog_irq rises 8 cycles after the push.
//     reset in the same cycle as an outstanding push -> FIFO empty, busy=0.

Source files
------------

// File: rtl/rocc_arb_pkg.sv
// Shared constants, payload struct and helpers for the RoCC command arbiter.
package rocc_arb_pkg;

  localparam int FUNCT_W  = 7;
  localparam int RD_W     = 5;
  // Widest operand the payload struct carries; narrower XLEN builds use the low bits.
  localparam int XLEN_MAX = 64;

  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic [FUNCT_W-1:0]  funct;
    logic [RD_W-1:0]     rd;
    logic                xd;
    logic [XLEN_MAX-1:0] rs1;
    logic [XLEN_MAX-1:0] rs2;
  } cmd_t;

endpackage

// File: rtl/rocc_id_fifo.sv
// In-order FIFO of source IDs for commands still awaiting a response.
// A push is dropped while full, even if a pop happens in the same cycle.
module rocc_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_id,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rocc_cmd_arbiter.sv
// Round-robin sharing of one RoCC accelerator among NREQ sources, with in-order
// response routing. Optional watchdog on stalled responses: ROCC_ARB_WDOG_EN.
module rocc_cmd_arbiter
  import rocc_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int XLEN           = 64,
  parameter int MAX_OUTST      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        src_cmd_valid,
  output logic [NREQ-1:0]        src_cmd_ready,
  input  logic [NREQ*FUNCT_W-1:0] src_cmd_funct,
  input  logic [NREQ*RD_W-1:0]   src_cmd_rd,
  input  logic [NREQ-1:0]        src_cmd_xd,
  input  logic [NREQ*XLEN-1:0]   src_cmd_rs1,
  input  logic [NREQ*XLEN-1:0]   src_cmd_rs2,
  output logic                   acc_cmd_valid,
  input  logic                   acc_cmd_ready,
  output logic [FUNCT_W-1:0]     acc_cmd_funct,
  output logic [RD_W-1:0]        acc_cmd_rd,
  output logic                   acc_cmd_xd,
  output logic [XLEN-1:0]        acc_cmd_rs1,
  output logic [XLEN-1:0]        acc_cmd_rs2,
  input  logic                   acc_resp_valid,
  output logic                   acc_resp_ready,
  input  logic [RD_W-1:0]        acc_resp_rd,
  input  logic [XLEN-1:0]        acc_resp_data,
  output logic [NREQ-1:0]        src_resp_valid,
  input  logic [NREQ-1:0]        src_resp_ready,
  output logic [RD_W-1:0]        src_resp_rd,
  output logic [XLEN-1:0]        src_resp_data,
  output logic                   busy,
  output logic                   err_spurious,
  output logic                   wdog_irq,
  input  logic                   err_clear
);

  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  cmd_t             src_cmd [NREQ];
  cmd_t             sel;
  logic [NREQ-1:0]  cand;
  logic             found;
  logic [ID_W-1:0]  new_idx;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  lock_idx;
  logic             locked;
  logic             cmd_fire;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             spurious;
  int               idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      src_cmd[i].funct = src_cmd_funct[i*FUNCT_W +: FUNCT_W];
      src_cmd[i].rd    = src_cmd_rd[i*RD_W +: RD_W];
      src_cmd[i].xd    = src_cmd_xd[i];
      src_cmd[i].rs1   = XLEN_MAX'(src_cmd_rs1[i*XLEN +: XLEN]);
      src_cmd[i].rs2   = XLEN_MAX'(src_cmd_rs2[i*XLEN +: XLEN]);
      cand[i]          = src_cmd_valid[i] & !(src_cmd_xd[i] & fifo_full);
    end
  end

  // Search from rr_ptr, which always names the source after the last one accepted.
  always_comb begin
    found   = 1'b0;
    new_idx = '0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(rr_ptr) + off) % NREQ;
      if (!found && cand[ID_W'(idx)]) begin
        found   = 1'b1;
        new_idx = ID_W'(idx);
      end
    end
  end

  // Valid/ready: a transfer happens on a cycle where valid and ready are both high;
  // once valid is raised the payload and grant stay fixed until that transfer.
  assign grant_idx     = locked ? lock_idx : new_idx;
  assign acc_cmd_valid = !reset & (locked | found);
  assign sel           = acc_cmd_valid ? src_cmd[grant_idx] : '0;
  assign cmd_fire      = acc_cmd_valid & acc_cmd_ready;
  assign src_cmd_ready = cmd_fire ? (NREQ'(1) << grant_idx) : '0;

  assign acc_cmd_funct = sel.funct;
  assign acc_cmd_rd    = sel.rd;
  assign acc_cmd_xd    = sel.xd;
  assign acc_cmd_rs1   = sel.rs1[XLEN-1:0];
  assign acc_cmd_rs2   = sel.rs2[XLEN-1:0];

  assign fifo_push = cmd_fire & sel.xd;

  rocc_id_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (ID_W)
  ) u_id_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (grant_idx),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .count   (fifo_count)
  );

  // With nothing outstanding the response is swallowed and flagged instead of routed.
  assign acc_resp_ready = reset ? 1'b0 : (fifo_empty ? 1'b1 : src_resp_ready[fifo_head]);
  assign src_resp_valid = (!reset && acc_resp_valid && !fifo_empty) ? (NREQ'(1) << fifo_head) : '0;
  assign src_resp_rd    = reset ? '0 : acc_resp_rd;
  assign src_resp_data  = reset ? '0 : acc_resp_data;
  assign fifo_pop       = acc_resp_valid & acc_resp_ready & !fifo_empty;
  assign spurious       = !reset & acc_resp_valid & fifo_empty;
  assign busy           = !reset & (acc_cmd_valid | (fifo_count != '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= '0;
      locked       <= 1'b0;
      lock_idx     <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (cmd_fire) begin
        locked <= 1'b0;
        rr_ptr <= (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (acc_cmd_valid) begin
        locked   <= 1'b1;
        lock_idx <= grant_idx;
      end
      if (spurious) begin
        err_spurious <= 1'b1;
      end else if (err_clear) begin
        err_spurious <= 1'b0;
      end
    end
  end

`ifdef ROCC_ARB_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  // The counter parks at the limit so the flag keeps reasserting until the stall ends.
  assign wd_hit = !fifo_empty && !fifo_pop && (wd_cnt == WD_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt   <= '0;
      wdog_irq <= 1'b0;
    end else begin
      if (fifo_empty || fifo_pop) begin
        wd_cnt <= '0;
      end else if (!wd_hit) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_hit) begin
        wdog_irq <= 1'b1;
      end else if (err_clear) begin
        wdog_irq <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign wdog_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_rocc_cmd_arbiter.sv
// Directed bench for rocc_cmd_arbiter (2 sources, depth-4 ID FIFO, timeout 8).
// Watchdog expectations follow ROCC_ARB_WDOG_EN.
module tb_rocc_cmd_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   src_cmd_valid;
  logic [NREQ-1:0]   src_cmd_ready;
  logic [NREQ*7-1:0] src_cmd_funct;
  logic [NREQ*5-1:0] src_cmd_rd;
  logic [NREQ-1:0]   src_cmd_xd;
  logic [NREQ*XLEN-1:0] src_cmd_rs1;
  logic [NREQ*XLEN-1:0] src_cmd_rs2;
  logic              acc_cmd_valid;
  logic              acc_cmd_ready;
  logic [6:0]        acc_cmd_funct;
  logic [4:0]        acc_cmd_rd;
  logic              acc_cmd_xd;
  logic [XLEN-1:0]   acc_cmd_rs1;
  logic [XLEN-1:0]   acc_cmd_rs2;
  logic              acc_resp_valid;
  logic              acc_resp_ready;
  logic [4:0]        acc_resp_rd;
  logic [XLEN-1:0]   acc_resp_data;
  logic [NREQ-1:0]   src_resp_valid;
  logic [NREQ-1:0]   src_resp_ready;
  logic [4:0]        src_resp_rd;
  logic [XLEN-1:0]   src_resp_data;
  logic              busy;
  logic              err_spurious;
  logic              wdog_irq;
  logic              err_clear;

  int total = 0;
  int bad   = 0;

  rocc_cmd_arbiter #(
    .NREQ(NREQ), .XLEN(XLEN), .MAX_OUTST(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .src_cmd_valid(src_cmd_valid), .src_cmd_ready(src_cmd_ready),
    .src_cmd_funct(src_cmd_funct), .src_cmd_rd(src_cmd_rd), .src_cmd_xd(src_cmd_xd),
    .src_cmd_rs1(src_cmd_rs1), .src_cmd_rs2(src_cmd_rs2),
    .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
    .acc_cmd_funct(acc_cmd_funct), .acc_cmd_rd(acc_cmd_rd), .acc_cmd_xd(acc_cmd_xd),
    .acc_cmd_rs1(acc_cmd_rs1), .acc_cmd_rs2(acc_cmd_rs2),
    .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
    .acc_resp_rd(acc_resp_rd), .acc_resp_data(acc_resp_data),
    .src_resp_valid(src_resp_valid), .src_resp_ready(src_resp_ready),
    .src_resp_rd(src_resp_rd), .src_resp_data(src_resp_data),
    .busy(busy), .err_spurious(err_spurious), .wdog_irq(wdog_irq), .err_clear(err_clear)
  );

  // Clock / reset
  always #5 clock = ~clock;

  // Driver tasks: inputs change 1 time unit after the rising edge, checks follow 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic xd, input logic [XLEN-1:0] a);
    src_cmd_valid[i]         = v;
    src_cmd_xd[i]            = xd;
    src_cmd_rs1[i*XLEN +: XLEN] = a;
    src_cmd_rs2[i*XLEN +: XLEN] = ~a;
    src_cmd_funct[i*7 +: 7]  = 7'(i + 3);
    src_cmd_rd[i*5 +: 5]     = 5'(i + 1);
  endtask

  task automatic idle_inputs();
    src_cmd_valid  = '0;
    src_cmd_xd     = '0;
    src_cmd_funct  = '0;
    src_cmd_rd     = '0;
    src_cmd_rs1    = '0;
    src_cmd_rs2    = '0;
    acc_cmd_ready  = 1'b0;
    acc_resp_valid = 1'b0;
    acc_resp_rd    = '0;
    acc_resp_data  = '0;
    src_resp_ready = 2'b11;
    err_clear      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    settle();
    total++; if (acc_cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %b want 0", acc_cmd_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (acc_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_resp_ready: got %b want 0", acc_resp_ready); end
    total++; if ({err_spurious, wdog_irq} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {err_spurious, wdog_irq}); end
    reset = 1'b0;
    settle();
    total++; if (acc_resp_ready !== 1'b1) begin bad++; $display("FAIL empty_resp_ready: got %b want 1", acc_resp_ready); end
  endtask

  task automatic test_single_source();
    set_src(1, 1'b1, 1'b0, 64'hA5A5_0000_1111_2222);
    acc_cmd_ready = 1'b1;
    settle();
    total++; if (acc_cmd_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", acc_cmd_valid); end
    total++; if (acc_cmd_rs1 !== 64'hA5A5_0000_1111_2222) begin bad++; $display("FAIL single_rs1: got %h want a5a5000011112222", acc_cmd_rs1); end
    total++; if (acc_cmd_rs2 !== ~64'hA5A5_0000_1111_2222) begin bad++; $display("FAIL single_rs2: got %h", acc_cmd_rs2); end
    total++; if ({acc_cmd_funct, acc_cmd_rd} !== {7'd4, 5'd2}) begin bad++; $display("FAIL single_funct_rd: got %h/%h want 4/2", acc_cmd_funct, acc_cmd_rd); end
    total++; if (src_cmd_ready !== 2'b10) begin bad++; $display("FAIL single_ready: got %b want 10", src_cmd_ready); end
    tick();
    set_src(1, 1'b0, 1'b0, '0);
    settle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    set_src(0, 1'b1, 1'b0, 64'h100);
    set_src(1, 1'b1, 1'b0, 64'h200);
    acc_cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      settle();
      total++; if (src_cmd_ready !== exp_g) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, src_cmd_ready, exp_g); end
      total++; if (acc_cmd_rs1 !== ((k % 2 == 0) ? 64'h100 : 64'h200)) begin bad++; $display("FAIL rr_rs1_%0d: got %h", k, acc_cmd_rs1); end
      tick();
    end
    // Pointer now favours source 0; only source 1 asks, so its grant must hold once source 0 joins.
    set_src(0, 1'b0, 1'b0, '0);
    acc_cmd_ready = 1'b0;
    settle();
    total++; if (acc_cmd_rs1 !== 64'h200 || src_cmd_ready !== 2'b00) begin bad++; $display("FAIL lock_first: got rs1=%h rdy=%b want 200/00", acc_cmd_rs1, src_cmd_ready); end
    tick();
    set_src(0, 1'b1, 1'b0, 64'h100);
    for (int k = 0; k < 2; k++) begin
      settle();
      total++; if (acc_cmd_valid !== 1'b1 || acc_cmd_rs1 !== 64'h200 || src_cmd_ready !== 2'b00) begin
        bad++; $display("FAIL lock_hold%0d: got v=%b rs1=%h rdy=%b want 1/200/00", k, acc_cmd_valid, acc_cmd_rs1, src_cmd_ready);
      end
      tick();
    end
    acc_cmd_ready = 1'b1;
    settle();
    total++; if (src_cmd_ready !== 2'b10) begin bad++; $display("FAIL lock_release: got %b want 10", src_cmd_ready); end
    tick();
    set_src(1, 1'b0, 1'b0, '0);
    settle();
    total++; if (src_cmd_ready !== 2'b01) begin bad++; $display("FAIL after_lock: got %b want 01", src_cmd_ready); end
    tick();
    set_src(0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_id_fifo_and_routing();
    int order [4] = '{0, 1, 1, 0};
    logic [1:0] exp_r;
    acc_cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_src(order[k], 1'b1, 1'b1, 64'(k));
      set_src(1 - order[k], 1'b0, 1'b0, '0);
      settle();
      exp_r = (order[k] == 0) ? 2'b01 : 2'b10;
      total++; if (src_cmd_ready !== exp_r) begin bad++; $display("FAIL fill%0d: got %b want %b", k, src_cmd_ready, exp_r); end
      tick();
    end
    set_src(0, 1'b1, 1'b0, 64'h400);
    set_src(1, 1'b1, 1'b1, 64'h300);
    settle();
    total++; if (src_cmd_ready !== 2'b01 || acc_cmd_xd !== 1'b0 || acc_cmd_rs1 !== 64'h400) begin
      bad++; $display("FAIL full_bypass: got rdy=%b xd=%b rs1=%h want 01/0/400", src_cmd_ready, acc_cmd_xd, acc_cmd_rs1);
    end
    tick();
    set_src(0, 1'b0, 1'b0, '0);
    settle();
    total++; if (acc_cmd_valid !== 1'b0 || src_cmd_ready !== 2'b00) begin bad++; $display("FAIL full_stall: got v=%b rdy=%b want 0/00", acc_cmd_valid, src_cmd_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", busy); end
    set_src(1, 1'b0, 1'b0, '0);
    // First response goes to source 0.
    acc_resp_valid = 1'b1;
    acc_resp_data  = 64'h1000;
    acc_resp_rd    = 5'd9;
    settle();
    total++; if (src_resp_valid !== 2'b01 || acc_resp_ready !== 1'b1) begin bad++; $display("FAIL resp0: got v=%b rdy=%b want 01/1", src_resp_valid, acc_resp_ready); end
    total++; if (src_resp_data !== 64'h1000 || src_resp_rd !== 5'd9) begin bad++; $display("FAIL resp0_data: got %h/%h want 1000/9", src_resp_data, src_resp_rd); end
    tick();
    // Head is now source 1, which stalls while source 0 is ready.
    src_resp_ready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      settle();
      total++; if (src_resp_valid !== 2'b10 || acc_resp_ready !== 1'b0) begin bad++; $display("FAIL resp_stall%0d: got v=%b rdy=%b want 10/0", k, src_resp_valid, acc_resp_ready); end
      tick();
    end
    src_resp_ready = 2'b11;
    for (int k = 1; k < 4; k++) begin
      exp_r = (order[k] == 0) ? 2'b01 : 2'b10;
      settle();
      total++; if (src_resp_valid !== exp_r || acc_resp_ready !== 1'b1) begin bad++; $display("FAIL resp%0d: got v=%b rdy=%b want %b/1", k, src_resp_valid, acc_resp_ready, exp_r); end
      tick();
    end
    acc_resp_valid = 1'b0;
    settle();
    total++; if (busy !== 1'b0 || err_spurious !== 1'b0) begin bad++; $display("FAIL drained: got busy=%b err=%b want 0/0", busy, err_spurious); end
  endtask

  task automatic test_spurious();
    acc_resp_valid = 1'b1;
    acc_resp_rd    = 5'd7;
    settle();
    total++; if (acc_resp_ready !== 1'b1 || src_resp_valid !== 2'b00) begin bad++; $display("FAIL spur_drop: got rdy=%b v=%b want 1/00", acc_resp_ready, src_resp_valid); end
    tick();
    acc_resp_valid = 1'b0;
    settle();
    total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_set: got %b want 1", err_spurious); end
    acc_resp_valid = 1'b1;
    err_clear      = 1'b1;
    tick();
    acc_resp_valid = 1'b0;
    err_clear      = 1'b0;
    settle();
    total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_set_wins: got %b want 1", err_spurious); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    settle();
    total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_clear: got %b want 0", err_spurious); end
  endtask

  task automatic test_watchdog_and_reset();
    logic exp_irq;
    acc_cmd_ready = 1'b1;
    set_src(0, 1'b1, 1'b1, 64'h500);
    tick();
    set_src(0, 1'b0, 1'b0, '0);
    for (int k = 1; k < 8; k++) tick();
    total++; if (wdog_irq !== 1'b0) begin bad++; $display("FAIL wdog_early: got %b want 0", wdog_irq); end
    tick();
`ifdef ROCC_ARB_WDOG_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    total++; if (wdog_irq !== exp_irq) begin bad++; $display("FAIL wdog_fire: got %b want %b", wdog_irq, exp_irq); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wdog_busy: got %b want 1", busy); end
    // Reset while one ID is outstanding and another xd=1 command is offered.
    set_src(1, 1'b1, 1'b1, 64'h600);
    reset = 1'b1;
    settle();
    total++; if (src_cmd_ready !== 2'b00) begin bad++; $display("FAIL rst_ready: got %b want 00", src_cmd_ready); end
    tick();
    reset = 1'b0;
    set_src(1, 1'b0, 1'b0, '0);
    settle();
    total++; if (busy !== 1'b0 || wdog_irq !== 1'b0) begin bad++; $display("FAIL rst_empty: got busy=%b irq=%b want 0/0", busy, wdog_irq); end
    acc_resp_valid = 1'b1;
    settle();
    total++; if (src_resp_valid !== 2'b00 || acc_resp_ready !== 1'b1) begin bad++; $display("FAIL rst_late_resp: got v=%b rdy=%b want 00/1", src_resp_valid, acc_resp_ready); end
    tick();
    acc_resp_valid = 1'b0;
    settle();
    total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL rst_spurious: got %b want 1", err_spurious); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_round_robin();
    test_id_fifo_and_routing();
    test_spurious();
    test_watchdog_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
